// File: rtl/proj_result_monitor.sv
// Result monitor for the processor frame: logs {out1,out2} changes with a cycle stamp and
// declares a PASS/FAIL verdict on a stable signature. Optional watchdog: RESULT_MON_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | watching out1, logging changes, cycle_count advancing
//   PASS     | out1 held PASS_CODE for STABLE_CYCLES samples (terminal)
//   FAIL     | out1 held FAIL_CODE for STABLE_CYCLES samples (terminal)
//   TIMEOUT  | watchdog expired in RUN without a verdict (terminal)
module proj_result_monitor #(
   parameter int unsigned DEPTH         = 16,
   parameter logic [31:0] PASS_CODE     = 32'h0000_0001,
   parameter logic [31:0] FAIL_CODE     = 32'hFFFF_FFFF,
   parameter int unsigned STABLE_CYCLES = 8,
   parameter int unsigned TIMEOUT_CYC   = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] out1,
   input  logic [31:0] out2,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [15:0] log_cycle,
   output logic [31:0] log_out1,
   output logic [31:0] log_out2,
   output logic        log_overflow,
   output logic [2:0]  state,
   output logic        done,
   output logic [31:0] cycle_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_PASS    = 3'd1,
      ST_FAIL    = 3'd2,
      ST_TIMEOUT = 3'd3
   } state_t;

   state_t        state_q, state_d;
   logic [63:0]   prev_q;
   logic [31:0]   cycle_count_q;
   logic [SW-1:0] stab_q, stab_d;

   logic [79:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          overflow_q;

   logic          in_run, chg, push, pop, full, wr_en;
   logic          is_code, verdict, wd_expire;
   logic [79:0]   head;

   assign in_run = (state_q == ST_RUN);
   assign chg    = ({out1, out2} != prev_q);
   assign push   = chg && in_run;
   assign full   = (count_q == FULL_CNT);
   assign pop    = log_valid && log_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign wr_en  = push && (!full || pop);

   assign is_code = (out1 == PASS_CODE) || (out1 == FAIL_CODE);

   always_comb begin
      stab_d = '0;
      if (is_code && (out1 == prev_q[63:32])) begin
         stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
      end else if (is_code) begin
         stab_d = SW'(1);
      end
   end

   assign verdict = in_run && (stab_d == STAB_MAX);

`ifdef RESULT_MON_TIMEOUT_EN
   logic [31:0] wd_q;

   // Down-counter tracks cycle_count: hitting 1 here means cycle_count reaches TIMEOUT_CYC next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q <= TIMEOUT_CYC;
      end else if (in_run && (wd_q != 32'd0)) begin
         wd_q <= wd_q - 32'd1;
      end
   end

   assign wd_expire = in_run && (wd_q == 32'd1);
`else
   logic [31:0] unused_timeout_cyc;

   assign unused_timeout_cyc = TIMEOUT_CYC;
   assign wd_expire          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (verdict) begin
               state_d = (out1 == PASS_CODE) ? ST_PASS : ST_FAIL;
            end else if (wd_expire) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         prev_q        <= '0;
         cycle_count_q <= '0;
         stab_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= {out1, out2};
         stab_q  <= stab_d;
         if (in_run && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_q <= cycle_count_q + 32'd1;
         end
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
         if (push && full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem[wr_ptr_q] <= {cycle_count_q[15:0], out1, out2};
      end
   end

   // Storage is not reset, so the head is masked while the FIFO is empty.
   assign head         = mem[rd_ptr_q];
   assign log_valid    = (count_q != '0);
   assign log_cycle    = log_valid ? head[79:64] : 16'd0;
   assign log_out1     = log_valid ? head[63:32] : 32'd0;
   assign log_out2     = log_valid ? head[31:0]  : 32'd0;
   assign log_overflow = overflow_q;
   assign state        = state_q;
   assign done         = (state_q != ST_RUN);
   assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_proj_result_monitor.sv
// Directed bench for proj_result_monitor: logging, FIFO full/overflow, verdicts and watchdog.
// Honours RESULT_MON_TIMEOUT_EN in the same way as the design.
module tb_proj_result_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] out1, out2;
   logic        log_valid, log_ready;
   logic [15:0] log_cycle;
   logic [31:0] log_out1, log_out2;
   logic        log_overflow;
   logic [2:0]  state;
   logic        done;
   logic [31:0] cycle_count;

   int n_chk = 0;
   int n_err = 0;

   proj_result_monitor #(
      .DEPTH         (16),
      .PASS_CODE     (32'h0000_0001),
      .FAIL_CODE     (32'hFFFF_FFFF),
      .STABLE_CYCLES (8),
      .TIMEOUT_CYC   (50)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .out1         (out1),
      .out2         (out2),
      .log_valid    (log_valid),
      .log_ready    (log_ready),
      .log_cycle    (log_cycle),
      .log_out1     (log_out1),
      .log_out2     (log_out2),
      .log_overflow (log_overflow),
      .state        (state),
      .done         (done),
      .cycle_count  (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset     = 1'b1;
      out1      = '0;
      out2      = '0;
      log_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      out1      = '0;
      out2      = '0;
      log_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", log_valid, 0);
      chk("rst_state", state, 0);
      chk("rst_done", done, 0);
      chk("rst_cc", cycle_count, 0);
      chk("rst_ovf", log_overflow, 0);
      chk("rst_out1", log_out1, 0);

      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("cc_count", cycle_count, i);
         chk("idle_valid", log_valid, 0);
      end

      // single change stamped at cycle 4, popped immediately
      tick();
      chk("cc4", cycle_count, 4);
      out1      = 32'd5;
      log_ready = 1'b1;
      #1;
      chk("push_same_cycle", log_valid, 0);
      tick();
      chk("one_valid", log_valid, 1);
      chk("one_cycle", log_cycle, 4);
      chk("one_out1", log_out1, 5);
      chk("one_out2", log_out2, 0);
      tick();
      chk("one_empty", log_valid, 0);

      // fill with 17 changes; the 17th is dropped
      reset_dut();
      for (int i = 1; i <= 17; i++) begin
         out1 = 32'd100 + 32'(i);
         out2 = 32'(i);
         tick();
      end
      chk("full_ovf", log_overflow, 1);
      chk("full_valid", log_valid, 1);
      chk("full_head_out1", log_out1, 101);
      chk("full_head_out2", log_out2, 1);
      chk("full_head_cycle", log_cycle, 0);
      tick();
      chk("stall_out1", log_out1, 101);
      chk("stall_cycle", log_cycle, 0);

      // push and pop together while full
      out1      = 32'd200;
      out2      = 32'd99;
      log_ready = 1'b1;
      tick();
      chk("pp_ovf", log_overflow, 1);
      for (int i = 2; i <= 16; i++) begin
         chk("drain_valid", log_valid, 1);
         chk("drain_out1", log_out1, 32'd100 + 32'(i));
         chk("drain_out2", log_out2, 32'(i));
         chk("drain_cycle", log_cycle, 16'(i - 1));
         tick();
      end
      chk("pp_new_valid", log_valid, 1);
      chk("pp_new_out1", log_out1, 200);
      chk("pp_new_out2", log_out2, 99);
      chk("pp_new_cycle", log_cycle, 18);
      tick();
      chk("drain_empty", log_valid, 0);
      chk("drain_ovf_sticky", log_overflow, 1);

      // PASS after 8 uninterrupted samples, interrupted at sample 5
      reset_dut();
      log_ready = 1'b1;
      for (int s = 1; s <= 13; s++) begin
         out1 = (s == 5) ? 32'd0 : 32'd1;
         tick();
         if (s < 13) chk("pass_wait_state", state, 0);
      end
      chk("pass_state", state, 1);
      chk("pass_done", done, 1);
      chk("pass_cc", cycle_count, 13);
      out1 = 32'd7;
      tick();
      tick();
      chk("pass_hold_state", state, 1);
      chk("pass_cc_frozen", cycle_count, 13);
      chk("pass_no_push", log_valid, 0);

      // FAIL code
      reset_dut();
      out1 = 32'hFFFF_FFFF;
      for (int s = 1; s <= 8; s++) begin
         tick();
         if (s == 7) chk("fail_wait_state", state, 0);
      end
      chk("fail_state", state, 2);
      chk("fail_done", done, 1);

      // verdict on the same edge the watchdog would fire
      reset_dut();
      repeat (42) tick();
      out1 = 32'd1;
      for (int s = 1; s <= 8; s++) begin
         tick();
         if (s == 7) chk("prio_wait_state", state, 0);
      end
      chk("prio_cc", cycle_count, 50);
      chk("prio_state", state, 1);

      // watchdog
      reset_dut();
      repeat (49) tick();
      chk("wd_pre_state", state, 0);
      chk("wd_pre_cc", cycle_count, 49);
      tick();
      chk("wd_cc", cycle_count, 50);
`ifdef RESULT_MON_TIMEOUT_EN
      chk("wd_state", state, 3);
      chk("wd_done", done, 1);
      tick();
      chk("wd_cc_frozen", cycle_count, 50);
      chk("wd_hold_state", state, 3);
`else
      chk("wd_state", state, 0);
      chk("wd_done", done, 0);
      repeat (10) tick();
      chk("wd_cc_run", cycle_count, 60);
      chk("wd_hold_state", state, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
